// File: rtl/md5_result_collector.sv
// Buffers 512-bit MD5 match blocks in a small FIFO and streams each one out as
// sixteen 32-bit words (M[0] first) over valid/ready, with hit and drop bookkeeping.
module md5_result_collector #(
  parameter int FIFO_DEPTH = 4,
  parameter int BLOCK_W    = 512,
  parameter int WORD_W     = 32,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          find_str,
  input  logic [BLOCK_W-1:0]            result_str,
  input  logic                          word_ready,
  output logic                          word_valid,
  output logic [WORD_W-1:0]             word_data,
  output logic                          word_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic [CNT_W-1:0]              hit_count,
  output logic                          overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int WORDS = BLOCK_W / WORD_W;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state_reg, state_next;
  logic [BLOCK_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]       count_reg, count_next;
  logic [BLOCK_W-1:0]   shift_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic [CNT_W-1:0]     hit_reg;
  logic                 overflow_reg;

  logic pop;
  logic push;
  logic handshake;
  logic sending;

  assign sending   = (state_reg == SEND);
  assign handshake = sending && word_ready;
  // A pop frees a slot at the same edge, so a full FIFO can still take a hit then.
  assign pop       = (state_reg == IDLE) && (count_reg != '0) && !clear;
  assign push      = find_str && !clear && ((count_reg < DEPTH_CNT) || pop);

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (count_reg != '0) state_next = SEND;
        SEND:    if (handshake && idx_reg == LAST_IDX) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Block storage carries no reset so it maps onto RAM; the read is registered
  // directly into the serializer shift register.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= result_str;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      idx_reg   <= '0;
    end else if (clear) begin
      shift_reg <= '0;
      idx_reg   <= '0;
    end else if (pop) begin
      shift_reg <= mem[rd_ptr_reg];
      idx_reg   <= '0;
    end else if (handshake) begin
      shift_reg <= shift_reg >> WORD_W;
      idx_reg   <= idx_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_reg      <= '0;
      overflow_reg <= 1'b0;
    end else if (clear) begin
      hit_reg      <= '0;
      overflow_reg <= 1'b0;
    end else if (find_str) begin
      if (hit_reg != {CNT_W{1'b1}}) hit_reg <= hit_reg + 1'b1;
      if (!push) overflow_reg <= 1'b1;
    end
  end

  assign word_valid = sending;
  assign word_data  = sending ? shift_reg[WORD_W-1:0] : '0;
  assign word_last  = sending && (idx_reg == LAST_IDX);
  assign busy       = sending;
  assign fifo_count = count_reg;
  assign hit_count  = hit_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_md5_result_collector.sv
// Scoreboard bench for md5_result_collector: stimulus queues expected words,
// a negedge monitor pops and compares them on every handshake.
module tb_md5_result_collector;

  logic         clk = 1'b0;
  logic         reset;
  logic         clear;
  logic         find_str;
  logic [511:0] result_str;
  logic         word_ready;
  logic         word_valid;
  logic [31:0]  word_data;
  logic         word_last;
  logic [2:0]   fifo_count;
  logic         busy;
  logic [15:0]  hit_count;
  logic         overflow;

  md5_result_collector dut (
    .clk(clk), .reset(reset), .clear(clear), .find_str(find_str),
    .result_str(result_str), .word_ready(word_ready), .word_valid(word_valid),
    .word_data(word_data), .word_last(word_last), .fifo_count(fifo_count),
    .busy(busy), .hit_count(hit_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int hs_total = 0;
  int ready_mode = 0;
  int cyc = 0;
  int hs0;
  logic [32:0] exp_q[$];
  logic        held_v = 1'b0;
  logic [32:0] held_w;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] make_block(input logic [31:0] base);
    logic [511:0] b;
    for (int k = 0; k < 16; k++) b[k*32 +: 32] = base + 32'(k);
    return b;
  endfunction

  task automatic expect_block(input logic [31:0] base);
    for (int k = 0; k < 16; k++) exp_q.push_back({(k == 15), base + 32'(k)});
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse(input logic [31:0] base);
    result_str = make_block(base);
    find_str = 1'b1;
    step();
    find_str = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || word_valid) && n < budget) begin
      step();
      n++;
    end
    check("drain_in_time", 64'(n < budget), 64'd1);
  endtask

  // Ready pattern: 0 = held low, 1 = held high, 2 = 1,0,0 repeating.
  always @(posedge clk) begin
    #1;
    cyc++;
    case (ready_mode)
      0:       word_ready = 1'b0;
      1:       word_ready = 1'b1;
      default: word_ready = (cyc % 3 == 0);
    endcase
  end

  always @(negedge clk) begin
    if (held_v && word_valid)
      check("hold_stable", 64'({word_last, word_data}), 64'(held_w));
    if (word_valid && word_ready) begin
      hs_total++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none", word_data);
      end else begin
        check("word", 64'({word_last, word_data}), 64'(exp_q.pop_front()));
      end
    end
    held_v = word_valid && !word_ready;
    held_w = {word_last, word_data};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; clear = 1'b0; find_str = 1'b0; result_str = '0; word_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    step();
    check("rst_valid", 64'(word_valid), 64'd0);
    check("rst_fifo", 64'(fifo_count), 64'd0);
    check("rst_hits", 64'(hit_count), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);

    // Single hit with latency checks
    ready_mode = 1;
    step();
    hs0 = hs_total;
    expect_block(32'h1000_0000);
    pulse(32'h1000_0000);
    check("lat_fifo1", 64'(fifo_count), 64'd1);
    check("lat_valid_n", 64'(word_valid), 64'd0);
    step();
    check("lat_valid_n1", 64'(word_valid), 64'd1);
    check("lat_word0", 64'(word_data), 64'h1000_0000);
    check("lat_fifo0", 64'(fifo_count), 64'd0);
    wait_drain(100);
    check("single_hs", 64'(hs_total - hs0), 64'd16);
    check("single_hits", 64'(hit_count), 64'd1);
    check("single_fifo", 64'(fifo_count), 64'd0);

    // Backpressure 1,0,0 pattern
    ready_mode = 2;
    hs0 = hs_total;
    expect_block(32'h1000_0000);
    pulse(32'h1000_0000);
    wait_drain(200);
    check("bp_hs", 64'(hs_total - hs0), 64'd16);
    check("bp_hits", 64'(hit_count), 64'd2);

    // Overflow: six strobes with the consumer stalled
    do_clear();
    check("clr_hits", 64'(hit_count), 64'd0);
    ready_mode = 0;
    step();
    for (int i = 0; i < 6; i++) begin
      if (i < 5) expect_block(32'hA000_0000 + 32'(i << 8));
      pulse(32'hA000_0000 + 32'(i << 8));
    end
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_hits", 64'(hit_count), 64'd6);
    check("ovf_fifo", 64'(fifo_count), 64'd4);
    check("ovf_busy", 64'(busy), 64'd1);
    hs0 = hs_total;
    ready_mode = 1;
    wait_drain(300);
    check("ovf_hs", 64'(hs_total - hs0), 64'd80);
    check("ovf_sticky", 64'(overflow), 64'd1);

    // Full FIFO with a strobe landing on the IDLE pop cycle
    do_clear();
    ready_mode = 0;
    step();
    for (int i = 0; i < 5; i++) begin
      expect_block(32'hB000_0000 + 32'(i << 8));
      pulse(32'hB000_0000 + 32'(i << 8));
    end
    check("full_fifo", 64'(fifo_count), 64'd4);
    check("full_ovf", 64'(overflow), 64'd0);
    hs0 = hs_total;
    ready_mode = 1;
    begin
      int n = 0;
      do begin step(); n++; end while (busy && n < 100);
      check("full_idle_seen", 64'(busy), 64'd0);
    end
    check("full_idle_fifo", 64'(fifo_count), 64'd4);
    expect_block(32'hB000_0500);
    pulse(32'hB000_0500);
    check("pop_push_fifo", 64'(fifo_count), 64'd4);
    check("pop_push_ovf", 64'(overflow), 64'd0);
    check("pop_push_hits", 64'(hit_count), 64'd6);
    wait_drain(300);
    check("full_hs", 64'(hs_total - hs0), 64'd96);

    // Clear after word 5 with two blocks queued
    for (int i = 0; i < 3; i++) begin
      expect_block(32'hC000_0000 + 32'(i << 8));
      pulse(32'hC000_0000 + 32'(i << 8));
    end
    hs0 = hs_total;
    begin
      int n = 0;
      while ((hs_total - hs0) < 6 && n < 50) begin step(); n++; end
      check("clr_reach_w5", 64'(n < 50), 64'd1);
    end
    check("clr_pre_fifo", 64'(fifo_count), 64'd2);
    clear = 1'b1;
    find_str = 1'b1;
    result_str = make_block(32'hDEAD_0000);
    step();
    clear = 1'b0;
    find_str = 1'b0;
    exp_q.delete();
    check("clr_valid", 64'(word_valid), 64'd0);
    check("clr_fifo", 64'(fifo_count), 64'd0);
    check("clr_hits_drop", 64'(hit_count), 64'd0);
    check("clr_ovf", 64'(overflow), 64'd0);
    repeat (5) step();
    check("clr_quiet", 64'(word_valid), 64'd0);

    // Asynchronous reset mid-block
    expect_block(32'hE000_0000);
    pulse(32'hE000_0000);
    repeat (4) step();
    #1;
    reset = 1'b1;
    #1;
    check("arst_valid", 64'(word_valid), 64'd0);
    check("arst_data", 64'(word_data), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_hits", 64'(hit_count), 64'd0);
    exp_q.delete();
    step();
    reset = 1'b0;
    step();
    hs0 = hs_total;
    expect_block(32'hF000_0000);
    pulse(32'hF000_0000);
    wait_drain(100);
    check("arst_hs", 64'(hs_total - hs0), 64'd16);
    check("arst_hits_after", 64'(hit_count), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
